// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Read-side drain engine for the shared dual-port word RAM. On a start
// command it reads a window of consecutive words, one per FETCH cycle, and
// serialises each 32-bit word onto a valid/ready byte stream. Bytes leave
// least-significant first.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   start                 one-cycle command strobe, honoured only when idle
//   start_addr            first word address of the window
//   word_count            number of words to drain
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse at the end of a command
//   error                 pulses with done when a command was rejected
//   mem_addr              word address to the RAM read port
//   mem_wdata, mem_enw    RAM write side, tied off (read-only engine)
//   mem_rdata             combinational RAM read data for mem_addr
//   out_data, out_valid   byte stream towards the sink
//   out_ready             sink ready
// ---------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int          WIDTH     = 32,
  parameter int unsigned BASE_ADDR = 206800,
  parameter int unsigned DEPTH     = 206800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_addr,
  input  logic [WIDTH-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE_ADDR);
  // One past the last legal word, kept one bit wider so it never wraps.
  localparam logic [WIDTH:0]   LIMIT  = (WIDTH+1)'(BASE_ADDR) + (WIDTH+1)'(DEPTH);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] remaining_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [1:0]       byte_idx_reg;
  logic             err_reg;

  logic [WIDTH:0]   end_sum;
  logic             reject;
  logic             xfer;

  // Window end computed with a carry bit: a huge start_addr + word_count
  // must be rejected, not wrap back into the legal range.
  assign end_sum = {1'b0, start_addr} + {1'b0, word_count};
  assign reject  = (word_count == '0) || (start_addr < BASE_W) || (end_sum > LIMIT);

  assign xfer = (state_reg == SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= BASE_W;
      remaining_reg <= '0;
      shift_reg     <= '0;
      byte_idx_reg  <= 2'd0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (reject) begin
              // Rejected commands leave the address register alone so
              // mem_addr never points outside the RAM window.
              err_reg   <= 1'b1;
              state_reg <= FIN;
            end else begin
              addr_reg      <= start_addr;
              remaining_reg <= word_count;
              state_reg     <= FETCH;
            end
          end
        end
        FETCH: begin
          // The only cycle the RAM is sampled; later writes to this word
          // by the other port are not seen.
          shift_reg    <= mem_rdata;
          byte_idx_reg <= 2'd0;
          state_reg    <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (byte_idx_reg != 2'd3) begin
              shift_reg    <= shift_reg >> 8;
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end else begin
              remaining_reg <= remaining_reg - WIDTH'(1);
              if (remaining_reg == WIDTH'(1)) begin
                state_reg <= FIN;
              end else begin
                addr_reg  <= addr_reg + WIDTH'(1);
                state_reg <= FETCH;
              end
            end
          end
        end
        default: begin
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);
  assign error     = (state_reg == FIN) && err_reg;
  assign out_valid = (state_reg == SEND);
  assign out_data  = shift_reg[7:0];
  assign mem_addr  = addr_reg;
  assign mem_wdata = '0;
  assign mem_enw   = 1'b0;

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

  localparam int unsigned BASE  = 206800;
  localparam int unsigned DEPTH = 206800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] word_count = '0;
  logic        busy, done, error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_enw;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  ram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enw(mem_enw),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // RAM contents as a pure function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd206800: return 32'h44332211;
      32'd206801: return 32'h88776655;
      32'd413599: return 32'hC0FFEE42;
      default:    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  assign mem_rdata = word_at(mem_addr);

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int rphase = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (rphase % 3 == 0); rphase++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream monitor, sampled mid-cycle.
  logic [7:0] byte_q[$];
  int first_valid, last_xfer, done_cnt, done_cyc;
  logic done_err;
  int stall_viol, const_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [31:0] prev_addr;

  initial forever begin
    @(negedge clk);
    if (mem_wdata !== 32'd0 || mem_enw !== 1'b0) const_viol++;
    if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || mem_addr !== prev_addr))
      stall_viol++;
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    prev_addr  = mem_addr;
    if (out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_xfer = cyc;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
    end
  end

  task automatic clear_mon();
    byte_q.delete();
    first_valid = -1;
    last_xfer   = -1;
    done_cnt    = 0;
    done_cyc    = -1;
    done_err    = 1'b0;
    stall_viol  = 0;
  endtask

  function automatic bit model_reject(input logic [31:0] a, input logic [31:0] n);
    longint e;
    e = longint'(a) + longint'(n);
    return (n == 0) || (a < BASE) || (e > longint'(BASE) + longint'(DEPTH));
  endfunction

  // Issue a command in cycle s; optionally pulse start again restart_at cycles later.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] n, input int mode,
                         input int restart_at, output int s);
    int k;
    ready_mode = mode;
    rphase = 0;
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; start_addr = a; word_count = n; s = cyc;
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      @(posedge clk); #1; k++;
      start = (k == restart_at);
      if (k == restart_at) begin start_addr = BASE; word_count = 1; end
    end
    if (done_cnt == 0) check("timeout_waiting_done", 0, 1);
    repeat (10) begin
      @(posedge clk); #1; k++;
      start = (k == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic verify_cmd(input string nm, input logic [31:0] a, input logic [31:0] n,
                            input int mode, input int s);
    bit rej;
    logic [7:0] exp_q[$];
    int nbad;
    logic [31:0] w;
    rej = model_reject(a, n);
    check({nm, "/done_count"}, done_cnt, 1);
    check({nm, "/error"}, done_err, rej);
    check({nm, "/busy_after"}, busy, 0);
    check({nm, "/stall_stable"}, stall_viol, 0);
    if (rej) begin
      check({nm, "/done_cycle"}, done_cyc, s + 1);
      check({nm, "/no_valid"}, first_valid, -1);
    end else begin
      for (int wi = 0; wi < int'(n); wi++) begin
        w = word_at(a + 32'(wi));
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
      end
      check({nm, "/byte_count"}, byte_q.size(), exp_q.size());
      nbad = 0;
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
        if (byte_q[i] !== exp_q[i]) nbad++;
      check({nm, "/byte_mismatches"}, nbad, 0);
      check({nm, "/first_valid_cycle"}, first_valid, s + 2);
      check({nm, "/done_after_last"}, done_cyc, last_xfer + 1);
      check({nm, "/mem_addr_end"}, mem_addr, a + n - 1);
      if (mode == 0) check({nm, "/drain_cycles"}, last_xfer - s, 5 * int'(n));
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] cnt;
    int          mode;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s;
    logic [31:0] ra, rn;
    int rm, sel;

    vecs[0] = '{32'd206800, 32'd2, 0, 1'b0};
    vecs[1] = '{32'd206800, 32'd2, 1, 1'b0};
    vecs[2] = '{32'd206800, 32'd0, 0, 1'b1};
    vecs[3] = '{32'd206799, 32'd1, 0, 1'b1};
    vecs[4] = '{32'd413599, 32'd2, 0, 1'b1};
    vecs[5] = '{32'd413599, 32'd1, 0, 1'b0};
    vecs[6] = '{32'd206810, 32'd3, 0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/error", error, 0);
    check("reset/out_valid", out_valid, 0);
    check("reset/out_data", out_data, 0);
    check("reset/mem_addr", mem_addr, BASE);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].addr, vecs[i].cnt, vecs[i].mode, -1, s);
      check($sformatf("vec%0d/table_error", i), done_err, vecs[i].exp_err);
      verify_cmd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].cnt, vecs[i].mode, s);
      if (i < 2) begin
        for (int b = 0; b < 8 && b < byte_q.size(); b++)
          check($sformatf("vec%0d/byte%0d", i, b), byte_q[b], 8'h11 * (b + 1));
      end
      $display("vec%0d addr=%0d count=%0d mode=%0d bytes=%0d err=%0d",
               i, vecs[i].addr, vecs[i].cnt, vecs[i].mode, byte_q.size(), done_err);
    end

    // Second start pulsed mid-transfer, then one in the FIN cycle.
    run_cmd(32'd206800, 32'd2, 0, 5, s);
    verify_cmd("restart_mid", 32'd206800, 32'd2, 0, s);
    $display("restart_mid done_count=%0d bytes=%0d", done_cnt, byte_q.size());
    run_cmd(32'd206805, 32'd1, 0, 6, s);
    verify_cmd("restart_fin", 32'd206805, 32'd1, 0, s);
    $display("restart_fin done_count=%0d bytes=%0d", done_cnt, byte_q.size());

    // Reset while sending byte index 2.
    ready_mode = 0;
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; start_addr = BASE; word_count = 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid/byte2_valid", out_valid, 1);
    check("rst_mid/byte2_data", out_data, 8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", busy, 0);
    check("rst_mid/done", done, 0);
    check("rst_mid/error", error, 0);
    check("rst_mid/out_valid", out_valid, 0);
    check("rst_mid/out_data", out_data, 0);
    check("rst_mid/mem_addr", mem_addr, BASE);
    run_cmd(32'd206801, 32'd1, 0, -1, s);
    verify_cmd("rst_fresh", 32'd206801, 32'd1, 0, s);
    if (byte_q.size() > 0) check("rst_fresh/byte0", byte_q[0], 8'h55);
    $display("rst_mid fresh bytes=%0d", byte_q.size());

    // Randomised commands against the reference model.
    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 3);
      rn  = 32'($urandom_range(0, 4));
      case (sel)
        0: ra = BASE + 32'($urandom_range(0, 20));
        1: ra = BASE + DEPTH - 32'($urandom_range(0, 5));
        2: ra = BASE - 32'($urandom_range(1, 3));
        default: begin ra = $urandom; if ($urandom_range(0, 1) == 1) rn = $urandom; end
      endcase
      rm = $urandom_range(0, 2);
      run_cmd(ra, rn, rm, -1, s);
      verify_cmd($sformatf("rand%0d", t), ra, rn, rm, s);
      $display("rand%0d addr=%0d count=%0d mode=%0d bytes=%0d err=%0d",
               t, ra, rn, rm, byte_q.size(), done_err);
    end

    check("write_port_tied_off", const_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
